pwm_capture: RTL

Memory-mapped PWM input-capture peripheral: the receiving end of the PWM output path. Samples an external PWM line and measures period and high time in clock cycles, latching results in read-only registers. Sits on the same address-decoded peripheral bus as the PWM generator. Raises an optional interrupt per completed measurement.

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/pwm_edge_sync.sv | 62 ++++++
 rtl/pwm_capture.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM peripherals: register offsets, field bit
// positions and the capture state encoding.
package pwm_pkg;

  // Register offsets within the decoded window
  localparam logic [31:0] OFF_CTRL   = 32'h00;
  localparam logic [31:0] OFF_STATUS = 32'h08;
  localparam logic [31:0] OFF_PERIOD = 32'h10;
  localparam logic [31:0] OFF_HIGH   = 32'h18;

  // CTRL fields
  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // STATUS fields
  localparam int STATUS_VALID_BIT    = 0;
  localparam int STATUS_OVERFLOW_BIT = 1;

  // Capture state machine encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } cap_state_t;

endpackage

// File: rtl/pwm_edge_sync.sv
// Brings the asynchronous PWM line into the clock domain and produces
// single-cycle rise/fall pulses.
// Build option: PWM_CAPTURE_GLITCH_FILTER_EN inserts a 3-sample stability
// filter between the synchronizer and the edge detector.
module pwm_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic pwm_in,
  output logic rise,
  output logic fall
);

  logic sync_1;
  logic sync_2;
  logic level_q;
  logic level_now;

  // Two-flop synchronizer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= pwm_in;
      sync_2 <= sync_1;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic hist_0;
  logic hist_1;

  // Two-deep history of synchronized samples for the stability check
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_0 <= 1'b0;
      hist_1 <= 1'b0;
    end else begin
      hist_0 <= sync_2;
      hist_1 <= hist_0;
    end
  end

  // Level follows the input only after three consecutive equal samples
  always_comb begin
    level_now = level_q;
    if ((sync_2 == hist_0) && (hist_0 == hist_1)) level_now = sync_2;
  end
`else
  assign level_now = sync_2;
`endif

  // Previous level, reference for the edge detector
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) level_q <= 1'b0;
    else        level_q <= level_now;
  end

  assign rise = level_now & ~level_q;
  assign fall = ~level_now & level_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM input-capture peripheral: measures period and high time of pwm_in in
// clock cycles and exposes them through a small register window.
// Build option: PWM_CAPTURE_GLITCH_FILTER_EN (see pwm_edge_sync).
// Bus: a read or write is one cycle with the strobe high and the address
// inside the window; read_data is registered and holds between reads.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int          N             = 64,
  parameter logic [31:0] base_address  = 32'h9000100,
  parameter int          address_width = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [31:0]  address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [N-1:0] write_data,
  output logic [N-1:0] read_data,
  input  logic         pwm_in,
  output logic         irq,
  output logic [1:0]   dbg_state
);

  localparam logic [31:0] WIN_MASK = 32'hFFFFFFFF << address_width;

  cap_state_t state, state_next;
  logic rise, fall;
  logic enable, irq_en, valid, overflow;
  logic [N-1:0] cnt, hi_latch, period_q, high_q, rd_mux;
  logic cnt_clr, cnt_load1, cnt_inc, latch_hi, capture, ovf_set;
  logic cs, sat, wr_ctrl, wr_status;
  logic [31:0] offset;
  logic unused_wdata;

  assign cs        = (address & WIN_MASK) == base_address;
  assign offset    = address & ~WIN_MASK;
  assign wr_ctrl   = mem_write & cs & (offset == OFF_CTRL);
  assign wr_status = mem_write & cs & (offset == OFF_STATUS);
  assign sat       = (cnt == {N{1'b1}});
  assign unused_wdata = ^write_data[N-1:2];

  pwm_edge_sync u_edge_sync (
    .clock  (clock),
    .reset  (reset),
    .pwm_in (pwm_in),
    .rise   (rise),
    .fall   (fall)
  );

  // Capture FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state: disable wins everywhere, saturation aborts a measurement
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (enable) state_next = ST_ARM;
      ST_ARM: begin
        if (!enable)   state_next = ST_IDLE;
        else if (rise) state_next = ST_HIGH;
      end
      ST_HIGH: begin
        if (!enable)   state_next = ST_IDLE;
        else if (sat)  state_next = ST_ARM;
        else if (fall) state_next = ST_LOW;
      end
      ST_LOW: begin
        if (!enable)   state_next = ST_IDLE;
        else if (sat)  state_next = ST_ARM;
        else if (rise) state_next = ST_HIGH;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: counter control, high latch, capture and overflow strobes
  always_comb begin
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    latch_hi  = 1'b0;
    capture   = 1'b0;
    ovf_set   = 1'b0;
    case (state)
      ST_ARM: begin
        if (enable && rise) cnt_load1 = 1'b1;
        else                cnt_clr   = 1'b1;
      end
      ST_HIGH: begin
        if (!enable)  cnt_clr = 1'b1;
        else if (sat) begin
          ovf_set = 1'b1;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc  = 1'b1;
          latch_hi = fall;
        end
      end
      ST_LOW: begin
        if (!enable)  cnt_clr = 1'b1;
        else if (sat) begin
          ovf_set = 1'b1;
          cnt_clr = 1'b1;
        end else if (rise) begin
          capture   = 1'b1;
          cnt_load1 = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Cycle counter; a rising edge restarts it at 1 so the value on the next
  // edge equals the number of cycles between edges
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         cnt <= '0;
    else if (cnt_clr)   cnt <= '0;
    else if (cnt_load1) cnt <= {{(N-1){1'b0}}, 1'b1};
    else if (cnt_inc)   cnt <= cnt + 1'b1;
  end

  // High time held until the period completes, then published with it
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi_latch <= '0;
      period_q <= '0;
      high_q   <= '0;
    end else begin
      if (latch_hi) hi_latch <= cnt;
      if (capture) begin
        period_q <= cnt;
        high_q   <= hi_latch;
      end
    end
  end

  // CTRL and STATUS; a set event in the same cycle beats a W1C
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable <= write_data[CTRL_ENABLE_BIT];
        irq_en <= write_data[CTRL_IRQ_EN_BIT];
      end
      if (capture)                                      valid <= 1'b1;
      else if (wr_status && write_data[STATUS_VALID_BIT]) valid <= 1'b0;
      if (ovf_set)                                         overflow <= 1'b1;
      else if (wr_status && write_data[STATUS_OVERFLOW_BIT]) overflow <= 1'b0;
    end
  end

  // Read mux; unmapped offsets return zero
  always_comb begin
    rd_mux = '0;
    case (offset)
      OFF_CTRL: begin
        rd_mux[CTRL_ENABLE_BIT] = enable;
        rd_mux[CTRL_IRQ_EN_BIT] = irq_en;
      end
      OFF_STATUS: begin
        rd_mux[STATUS_VALID_BIT]    = valid;
        rd_mux[STATUS_OVERFLOW_BIT] = overflow;
      end
      OFF_PERIOD: rd_mux = period_q;
      OFF_HIGH:   rd_mux = high_q;
      default:    rd_mux = '0;
    endcase
  end

  // Registered read data, held when no selected read is active
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)               read_data <= '0;
    else if (mem_read && cs)  read_data <= rd_mux;
  end

  assign irq       = irq_en & (valid | overflow);
  assign dbg_state = state;

endmodule
